// File: rtl/axi_llc_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module   : axi_llc_cfg_seq
// Brief    : Turns one flush/SPM command into the ordered RegBus write,
//            commit and poll sequence for the LLC configuration registers.
// Revision : 1.0 - initial release
// ============================================================================
module axi_llc_cfg_seq #(
    parameter int unsigned SetAssociativity = 8,
    parameter logic [31:0] RegBaseAddr      = 32'h0,
    parameter logic [31:0] SpmOffset        = 32'h00,
    parameter logic [31:0] FlushOffset      = 32'h08,
    parameter logic [31:0] CommitOffset     = 32'h10,
    parameter logic [31:0] FlushedOffset    = 32'h18,
    parameter int unsigned PollInterval     = 16,
    parameter int unsigned MaxPolls         = 1024
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        cmd_valid_i,
    output logic                        cmd_ready_o,
    input  logic [SetAssociativity-1:0] cmd_spm_i,
    input  logic [SetAssociativity-1:0] cmd_flush_i,
    output logic                        done_valid_o,
    input  logic                        done_ready_i,
    output logic                        done_error_o,
    output logic                        done_timeout_o,
    output logic                        busy_o,
    output logic [31:0]                 conf_req_addr_o,
    output logic                        conf_req_write_o,
    output logic [31:0]                 conf_req_wdata_o,
    output logic [3:0]                  conf_req_wstrb_o,
    output logic                        conf_req_valid_o,
    input  logic [31:0]                 conf_rsp_rdata_i,
    input  logic                        conf_rsp_error_i,
    input  logic                        conf_rsp_ready_i
);

    localparam int unsigned c_POLL_W = $clog2(MaxPolls + 1);
    localparam int unsigned c_WAIT_W = $clog2(PollInterval + 1);
    localparam logic [c_POLL_W-1:0] c_MAX_POLLS = c_POLL_W'(MaxPolls);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(PollInterval - 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_SAT  = c_WAIT_W'(PollInterval);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WR_FLUSH   = 3'd1,
        S_WR_CMT_F   = 3'd2,
        S_RD_FLUSHED = 3'd3,
        S_WAIT       = 3'd4,
        S_WR_SPM     = 3'd5,
        S_WR_CMT_S   = 3'd6,
        S_DONE       = 3'd7
    } state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    // Request fields for the transfer issued on entry to state s; idle states get all-zero.
    function automatic req_t f_req(input state_t s, input logic [SetAssociativity-1:0] payload);
        req_t r;
        r = '0;
        case (s)
            S_WR_FLUSH: begin
                r = '{1'b1, RegBaseAddr + FlushOffset, 1'b1, 32'(payload), 4'hF};
            end
            S_WR_CMT_F, S_WR_CMT_S: begin
                r = '{1'b1, RegBaseAddr + CommitOffset, 1'b1, 32'h1, 4'hF};
            end
            S_RD_FLUSHED: begin
                r = '{1'b1, RegBaseAddr + FlushedOffset, 1'b0, 32'h0, 4'h0};
            end
            S_WR_SPM: begin
                r = '{1'b1, RegBaseAddr + SpmOffset, 1'b1, 32'(payload), 4'hF};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    state_t                        r_state;
    req_t                          r_req;
    logic [SetAssociativity-1:0]   r_spm;
    logic [SetAssociativity-1:0]   r_flush;
    logic                          r_error;
    logic                          r_timeout;
    logic [c_POLL_W-1:0]           r_poll_cnt;
    logic [c_WAIT_W-1:0]           r_wait_cnt;

    logic [SetAssociativity-1:0]   w_cmd_flush;
    logic                          w_xfer;
    logic                          w_hit;
    logic [c_POLL_W-1:0]           w_poll_next;
    logic                          w_unused_rdata;

    assign w_cmd_flush    = cmd_flush_i | cmd_spm_i;
    assign w_xfer         = r_req.valid & conf_rsp_ready_i;
    assign w_hit          = (conf_rsp_rdata_i[SetAssociativity-1:0] & r_flush) == r_flush;
    assign w_poll_next    = r_poll_cnt + 1'b1;
    assign w_unused_rdata = ^conf_rsp_rdata_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_req      <= '0;
            r_spm      <= '0;
            r_flush    <= '0;
            r_error    <= 1'b0;
            r_timeout  <= 1'b0;
            r_poll_cnt <= '0;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        r_spm      <= cmd_spm_i;
                        r_flush    <= w_cmd_flush;
                        r_error    <= 1'b0;
                        r_timeout  <= 1'b0;
                        r_poll_cnt <= '0;
                        if (|w_cmd_flush) begin
                            r_state <= S_WR_FLUSH;
                            r_req   <= f_req(S_WR_FLUSH, w_cmd_flush);
                        end else begin
                            r_state <= S_WR_SPM;
                            r_req   <= f_req(S_WR_SPM, cmd_spm_i);
                        end
                    end
                end
                S_WAIT: begin
                    if (r_wait_cnt == c_WAIT_LAST) begin
                        r_state <= S_RD_FLUSHED;
                        r_req   <= f_req(S_RD_FLUSHED, '0);
                    end else if (r_wait_cnt != c_WAIT_SAT) begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (done_ready_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    // Any errored response aborts the rest of the sequence; read data is discarded.
                    if (w_xfer && conf_rsp_error_i) begin
                        r_error <= 1'b1;
                        r_state <= S_DONE;
                        r_req   <= '0;
                    end else if (w_xfer) begin
                        case (r_state)
                            S_WR_FLUSH: begin
                                r_state <= S_WR_CMT_F;
                                r_req   <= f_req(S_WR_CMT_F, '0);
                            end
                            S_WR_CMT_F: begin
                                r_state <= S_RD_FLUSHED;
                                r_req   <= f_req(S_RD_FLUSHED, '0);
                            end
                            S_RD_FLUSHED: begin
                                r_poll_cnt <= w_poll_next;
                                if (w_hit) begin
                                    r_state <= S_WR_SPM;
                                    r_req   <= f_req(S_WR_SPM, r_spm);
                                end else if (w_poll_next == c_MAX_POLLS) begin
                                    r_timeout <= 1'b1;
                                    r_state   <= S_DONE;
                                    r_req     <= '0;
                                end else begin
                                    r_wait_cnt <= '0;
                                    r_state    <= S_WAIT;
                                    r_req      <= '0;
                                end
                            end
                            S_WR_SPM: begin
                                r_state <= S_WR_CMT_S;
                                r_req   <= f_req(S_WR_CMT_S, '0);
                            end
                            default: begin
                                r_state <= S_DONE;
                                r_req   <= '0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign cmd_ready_o      = (r_state == S_IDLE);
    assign busy_o           = (r_state != S_IDLE);
    assign done_valid_o     = (r_state == S_DONE);
    assign done_error_o     = r_error;
    assign done_timeout_o   = r_timeout;
    assign conf_req_valid_o = r_req.valid;
    assign conf_req_addr_o  = r_req.addr;
    assign conf_req_write_o = r_req.write;
    assign conf_req_wdata_o = r_req.wdata;
    assign conf_req_wstrb_o = r_req.wstrb;

endmodule
`default_nettype wire

// File: tb/tb_axi_llc_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_llc_cfg_seq
// Brief    : Directed and randomized checks of the configuration sequencer
//            against a transaction-list reference model and a RegBus responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_llc_cfg_seq;

    localparam int unsigned SA = 8;
    localparam int unsigned PI = 16;
    localparam int unsigned MP = 4;
    localparam logic [31:0] A_SPM     = 32'h00;
    localparam logic [31:0] A_FLUSH   = 32'h08;
    localparam logic [31:0] A_CMT     = 32'h10;
    localparam logic [31:0] A_FLUSHED = 32'h18;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } xfer_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [SA-1:0] cmd_spm;
    logic [SA-1:0] cmd_flush;
    logic          done_valid;
    logic          done_ready;
    logic          done_error;
    logic          done_timeout;
    logic          busy;
    logic [31:0]   req_addr;
    logic          req_write;
    logic [31:0]   req_wdata;
    logic [3:0]    req_wstrb;
    logic          req_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_error;
    logic          rsp_ready;

    axi_llc_cfg_seq #(
        .SetAssociativity (SA),
        .RegBaseAddr      (32'h0),
        .SpmOffset        (A_SPM),
        .FlushOffset      (A_FLUSH),
        .CommitOffset     (A_CMT),
        .FlushedOffset    (A_FLUSHED),
        .PollInterval     (PI),
        .MaxPolls         (MP)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .cmd_valid_i      (cmd_valid),
        .cmd_ready_o      (cmd_ready),
        .cmd_spm_i        (cmd_spm),
        .cmd_flush_i      (cmd_flush),
        .done_valid_o     (done_valid),
        .done_ready_i     (done_ready),
        .done_error_o     (done_error),
        .done_timeout_o   (done_timeout),
        .busy_o           (busy),
        .conf_req_addr_o  (req_addr),
        .conf_req_write_o (req_write),
        .conf_req_wdata_o (req_wdata),
        .conf_req_wstrb_o (req_wstrb),
        .conf_req_valid_o (req_valid),
        .conf_rsp_rdata_i (rsp_rdata),
        .conf_rsp_error_i (rsp_error),
        .conf_rsp_ready_i (rsp_ready)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scenario knobs, written only by the main sequence.
    int          seq = 0;
    bit          cfg_tie = 1'b1;
    int          cfg_stall = 0;
    int          cfg_misses = 0;
    int          cfg_err_idx = -1;
    logic [SA-1:0] cfg_fq = '0;

    // RegBus responder: optional stall per transfer, status data derived from the miss count.
    initial begin : responder
        int  last_seq;
        bit  in_xfer, completing, was_write;
        int  stall_left, xfer_idx, rd_idx;
        last_seq = 0; in_xfer = 0; completing = 0; was_write = 0;
        stall_left = 0; xfer_idx = 0; rd_idx = 0;
        rsp_ready = 1'b0; rsp_error = 1'b0; rsp_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (completing) begin
                completing = 0;
                in_xfer    = 0;
                xfer_idx++;
                if (!was_write) rd_idx++;
            end
            if (seq != last_seq || !rst_n) begin
                last_seq = seq; in_xfer = 0; completing = 0; xfer_idx = 0; rd_idx = 0;
            end
            if (req_valid && !in_xfer) begin
                in_xfer    = 1;
                stall_left = cfg_stall;
            end
            rsp_error = 1'b0;
            rsp_rdata = $urandom;
            if (req_valid) begin
                if (stall_left > 0) begin
                    rsp_ready = 1'b0;
                    stall_left--;
                end else begin
                    rsp_ready  = 1'b1;
                    completing = 1;
                    was_write  = req_write;
                    rsp_error  = (xfer_idx == cfg_err_idx);
                    if (!req_write)
                        rsp_rdata = (rd_idx < cfg_misses) ? ($urandom & ~32'(cfg_fq))
                                                          : ($urandom | 32'(cfg_fq));
                end
            end else begin
                rsp_ready = cfg_tie;
            end
        end
    end

    // Transfer monitor and request-stability watcher.
    xfer_t       obs_q[$];
    int unsigned obs_cyc[$];
    int          stab_err = 0;
    initial begin : monitor
        xfer_t cur, prev;
        bit    prev_stall;
        prev_stall = 0; prev = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 0;
            end else begin
                cur = {req_addr, req_write, req_wdata, req_wstrb};
                if (prev_stall && (!req_valid || cur != prev)) stab_err++;
                if (req_valid && rsp_ready) begin
                    obs_q.push_back(cur);
                    obs_cyc.push_back(cyc);
                end
                prev_stall = req_valid && !rsp_ready;
                prev       = cur;
            end
        end
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string scen, input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: observed %0h expected %0h", scen, tag, obs, exp);
        end
    endtask

    task automatic summary_and_finish();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    endtask

    // Reference model: expected transfer list, flags and done latency.
    xfer_t exp_q[$];
    bit    exp_err, exp_to;
    int    exp_lat;

    function automatic xfer_t wr(input logic [31:0] a, input logic [31:0] d);
        return {a, 1'b1, d, 4'hF};
    endfunction

    function automatic void build_model(input logic [SA-1:0] spm, input logic [SA-1:0] flush,
                                        input int misses, input int err_idx, input int stall);
        logic [SA-1:0] fq;
        int n;
        bit hit;
        fq = spm | flush;
        exp_q.delete();
        exp_err = 0;
        exp_to  = 0;
        if (fq != 0) begin
            exp_q.push_back(wr(A_FLUSH, 32'(fq)));
            exp_q.push_back(wr(A_CMT, 32'h1));
            n = 0;
            hit = 0;
            while (n < int'(MP) && !hit) begin
                exp_q.push_back({A_FLUSHED, 1'b0, 32'h0, 4'h0});
                n++;
                if (n > misses) hit = 1;
            end
            exp_to = !hit;
        end
        if (!exp_to) begin
            exp_q.push_back(wr(A_SPM, 32'(spm)));
            exp_q.push_back(wr(A_CMT, 32'h1));
        end
        if (err_idx >= 0 && err_idx < exp_q.size()) begin
            while (exp_q.size() > err_idx + 1) void'(exp_q.pop_back());
            exp_err = 1;
            exp_to  = 0;
        end
        exp_lat = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            exp_lat += 1 + stall;
            if (!exp_q[i].write && i + 1 < exp_q.size() && !exp_q[i+1].write) exp_lat += PI;
        end
        exp_lat += 1;
    endfunction

    task automatic chk_reset_vals(input string scen);
        chk(scen, "rst_cmd_ready",  cmd_ready,    1);
        chk(scen, "rst_busy",       busy,         0);
        chk(scen, "rst_done_valid", done_valid,   0);
        chk(scen, "rst_done_error", done_error,   0);
        chk(scen, "rst_done_to",    done_timeout, 0);
        chk(scen, "rst_req_valid",  req_valid,    0);
        chk(scen, "rst_req_fields", {req_addr, req_write, req_wdata, req_wstrb}, 0);
    endtask

    task automatic start_cmd(input string scen, input logic [SA-1:0] spm, input logic [SA-1:0] flush,
                             input int misses, input int err_idx, input int stall, input bit tie,
                             output int unsigned c0, output int start);
        build_model(spm, flush, misses, err_idx, stall);
        cfg_fq = spm | flush; cfg_misses = misses; cfg_err_idx = err_idx;
        cfg_stall = stall; cfg_tie = tie;
        seq++;
        start = obs_q.size();
        @(posedge clk); #1;
        chk(scen, "cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_spm = spm; cmd_flush = flush;
        c0 = cyc;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_spm = SA'($urandom); cmd_flush = SA'($urandom);
        chk(scen, "busy_after_accept", busy, 1);
        chk(scen, "cmd_ready_busy", cmd_ready, 0);
    endtask

    task automatic run_cmd(input string scen, input logic [SA-1:0] spm, input logic [SA-1:0] flush,
                           input int misses, input int err_idx, input int stall, input bit tie,
                           input int hold, input bit check_gaps);
        int unsigned c0;
        int start, n, nobs, last_rd;
        start_cmd(scen, spm, flush, misses, err_idx, stall, tie, c0, start);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_valid && n < 4000);
        if (!done_valid) begin
            n_cmp++; n_fail++;
            $error("FAIL %s/done_wait: observed no done expected done within 4000 cycles", scen);
            summary_and_finish();
        end
        chk(scen, "done_latency", cyc - c0, exp_lat);
        chk(scen, "done_error",   done_error,   exp_err);
        chk(scen, "done_timeout", done_timeout, exp_to);
        nobs = obs_q.size() - start;
        chk(scen, "xfer_count", nobs, exp_q.size());
        for (int i = 0; i < nobs && i < exp_q.size(); i++)
            chk(scen, $sformatf("xfer%0d", i), obs_q[start+i], exp_q[i]);
        if (check_gaps) begin
            last_rd = -1;
            for (int i = start; i < obs_q.size(); i++) begin
                if (!obs_q[i].write) begin
                    if (last_rd >= 0) chk(scen, "poll_gap", obs_cyc[i] - obs_cyc[last_rd], PI + 1);
                    last_rd = i;
                end
            end
        end
        chk(scen, "req_stable", stab_err, 0);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk(scen, "done_held", done_valid, 1);
            chk(scen, "cmd_ready_held", cmd_ready, 0);
            chk(scen, "flags_held", {done_error, done_timeout}, {exp_err, exp_to});
        end
        @(posedge clk); #1;
        done_ready = 1'b1;
        @(posedge clk); #1;
        done_ready = 1'b0;
        chk(scen, "idle_after_done", {cmd_ready, busy, done_valid}, 3'b100);
    endtask

    initial begin : main
        int unsigned c0;
        int start, n;
        logic [SA-1:0] s, f;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_spm = '0; cmd_flush = '0; done_ready = 1'b0;
        #3;
        chk_reset_vals("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_cmd("flush_first", 8'h03, 8'h00, 0, -1, 0, 1'b1, 0, 1'b0);
        run_cmd("no_flush",    8'h00, 8'h00, 0, -1, 0, 1'b1, 0, 1'b0);
        run_cmd("slow_flush",  8'h00, 8'h10, 3, -1, 0, 1'b1, 0, 1'b1);
        f = SA'($urandom) | 8'h01;
        run_cmd("timeout",     8'h00, f, 1000, -1, 0, 1'b1, 0, 1'b1);
        run_cmd("err_cmt_f",   SA'($urandom), 8'h21, 0, 1, 0, 1'b1, 0, 1'b0);
        run_cmd("backpressure", SA'($urandom), SA'($urandom) | 8'h80, 1, -1, 5, 1'b0, 0, 1'b0);
        run_cmd("done_hold",   8'h05, 8'h40, 0, -1, 0, 1'b1, 10, 1'b0);

        // Asynchronous reset while the sequencer sits in its poll wait.
        start_cmd("reset_wait", 8'h00, 8'h0C, 3, -1, 0, 1'b1, c0, start);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(busy && !req_valid && obs_q.size() >= start + 3) && n < 200);
        chk("reset_wait", "reached_wait", busy && !req_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("reset_wait");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_cmd("after_reset", 8'h81, 8'h02, 1, -1, 0, 1'b1, 2, 1'b1);

        for (int it = 0; it < 6; it++) begin
            int st;
            s  = SA'($urandom);
            f  = SA'($urandom);
            st = $urandom_range(0, 2);
            run_cmd($sformatf("rand%0d", it), s, f, $urandom_range(0, 5),
                    ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 6)) : -1,
                    st, (st == 0), $urandom_range(0, 3), (st == 0));
        end

        summary_and_finish();
    end

endmodule
`default_nettype wire
